// File: rtl/la_miner_ctrl_pkg.sv
// Shared constants for the LA miner command front end: opcodes, FSM codes,
// LA bit positions and the status-word builder.
package miner_la_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_LOAD_WORD = 3'd1;
    localparam logic [2:0] OP_SET_NONCE = 3'd2;
    localparam logic [2:0] OP_START     = 3'd3;
    localparam logic [2:0] OP_ABORT     = 3'd4;
    localparam logic [2:0] OP_CLEAR_ERR = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int LA_OP_LSB   = 32;
    localparam int LA_IDX_LSB  = 40;
    localparam int LA_STRB_BIT = 63;

    localparam int LA_BUSY_BIT  = 32;
    localparam int LA_DONE_BIT  = 33;
    localparam int LA_FOUND_BIT = 34;
    localparam int LA_ERR_BIT   = 35;
    localparam int LA_IRQ_BIT   = 36;

    localparam logic [7:0] STATUS_TAG_DEFAULT = 8'hAB;

    function automatic logic [15:0] status_word(input logic [7:0] tag,
                                                input logic [1:0] st,
                                                input logic       found);
        return {tag, 2'b01, st, 3'b000, found};
    endfunction

endpackage

// File: rtl/la_miner_ctrl_if.sv
// Header-stream and job-control bus between the LA front end (master)
// and the SHA3 miner core (slave).
interface la_miner_ctrl_if #(
    parameter int WORD_W = 32
) ();
    logic              hdr_valid;
    logic [7:0]        hdr_idx;
    logic [WORD_W-1:0] hdr_data;
    logic              hdr_ready;
    logic              core_start;
    logic [WORD_W-1:0] nonce_start;
    logic              core_abort;
    logic              core_done;
    logic              core_found;
    logic [WORD_W-1:0] core_nonce;

    modport master (
        output hdr_valid, hdr_idx, hdr_data, core_start, nonce_start, core_abort,
        input  hdr_ready, core_done, core_found, core_nonce
    );

    modport slave (
        input  hdr_valid, hdr_idx, hdr_data, core_start, nonce_start, core_abort,
        output hdr_ready, core_done, core_found, core_nonce
    );
endinterface

// File: rtl/la_miner_ctrl_cmd_capture.sv
// Two-stage LA command register with oenb field masking and strobe-toggle
// detection; emits one-cycle cmd_fire with the decoded fields.
module la_cmd_capture
    import miner_la_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [127:0]      la_data_i,
    input  logic [127:0]      la_oenb_i,
    output logic              cmd_fire_o,
    output logic [2:0]        cmd_op_o,
    output logic [7:0]        cmd_idx_o,
    output logic [WORD_W-1:0] cmd_data_o
);
    logic              strb_in_s;
    logic [2:0]        op_in_s;
    logic [7:0]        idx_in_s;
    logic [WORD_W-1:0] data_in_s;
    logic              unused_s;

    logic              strb_q;
    logic              strb_qq;
    logic [2:0]        op_q;
    logic [7:0]        idx_q;
    logic [WORD_W-1:0] data_q;

    assign data_in_s = (la_oenb_i[WORD_W-1:0] == {WORD_W{1'b0}}) ? la_data_i[WORD_W-1:0] : {WORD_W{1'b0}};
    assign op_in_s   = (la_oenb_i[LA_OP_LSB +: 3] == 3'd0) ? la_data_i[LA_OP_LSB +: 3] : 3'd0;
    assign idx_in_s  = (la_oenb_i[LA_IDX_LSB +: 8] == 8'd0) ? la_data_i[LA_IDX_LSB +: 8] : 8'd0;
    assign strb_in_s = la_data_i[LA_STRB_BIT] & ~la_oenb_i[LA_STRB_BIT];

    assign unused_s = ^{la_data_i[127:64], la_data_i[62:48], la_data_i[39:35],
                        la_oenb_i[127:64], la_oenb_i[62:48], la_oenb_i[39:35]};

    // Reset preloads both strobe stages from the pin so a held strobe level never fires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strb_q  <= strb_in_s;
            strb_qq <= strb_in_s;
            op_q    <= 3'd0;
            idx_q   <= 8'd0;
            data_q  <= {WORD_W{1'b0}};
        end else begin
            strb_q  <= strb_in_s;
            strb_qq <= strb_q;
            op_q    <= op_in_s;
            idx_q   <= idx_in_s;
            data_q  <= data_in_s;
        end
    end

    assign cmd_fire_o = strb_q ^ strb_qq;
    assign cmd_op_o   = op_q;
    assign cmd_idx_o  = idx_q;
    assign cmd_data_o = data_q;

endmodule

// File: rtl/la_miner_ctrl.sv
// LA command front end for the SHA3-256 miner: header buffer, job FSM, result capture.
// Optional LA_MINER_IRQ_EN adds an irq pulse on DONE entry and a pending bit on la_data_out[36].
module la_miner_ctrl
    import miner_la_pkg::*;
#(
    parameter int         HDR_WORDS  = 19,
    parameter int         WORD_W     = 32,
    parameter logic [7:0] STATUS_TAG = STATUS_TAG_DEFAULT
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [15:0]  status_o,
`ifdef LA_MINER_IRQ_EN
    output logic         irq,
`endif
    la_miner_ctrl_if.master core
);
    localparam int         IDX_W    = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam logic [7:0] LAST_IDX = 8'(HDR_WORDS - 1);

    logic              cmd_fire_s;
    logic [2:0]        cmd_op_s;
    logic [7:0]        cmd_idx_s;
    logic [WORD_W-1:0] cmd_data_s;

    logic [1:0]        state_q, state_d;
    logic [7:0]        widx_q, widx_d;
    logic [WORD_W-1:0] nonce_q, nonce_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              found_q, found_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic [WORD_W-1:0] hdr_q [HDR_WORDS];
    logic              hdr_we_s;
    logic              busy_s, hdr_valid_s, abort_s;
    logic [127:0]      la_out_s;
`ifdef LA_MINER_IRQ_EN
    logic              irq_q, irq_d;
    logic              pend_q, pend_d;
`endif

    la_cmd_capture #(.WORD_W(WORD_W)) u_cap (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .la_data_i  (la_data_in),
        .la_oenb_i  (la_oenb),
        .cmd_fire_o (cmd_fire_s),
        .cmd_op_o   (cmd_op_s),
        .cmd_idx_o  (cmd_idx_s),
        .cmd_data_o (cmd_data_s)
    );

    assign busy_s      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign hdr_valid_s = (state_q == ST_LOAD);
    assign abort_s     = cmd_fire_s && (cmd_op_s == OP_ABORT) && busy_s;

    // Job FSM and command execution; ABORT outranks both the handshake and core_done.
    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        nonce_d  = nonce_q;
        res_d    = res_q;
        found_d  = found_q;
        done_d   = done_q;
        err_d    = err_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        hdr_we_s = 1'b0;
`ifdef LA_MINER_IRQ_EN
        irq_d    = 1'b0;
        pend_d   = pend_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (core.hdr_ready) begin
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        start_d = 1'b1;
                    end else begin
                        widx_d = widx_q + 8'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (core.core_done) begin
                    state_d = ST_DONE;
                    found_d = core.core_found;
                    res_d   = core.core_nonce;
                    done_d  = 1'b1;
`ifdef LA_MINER_IRQ_EN
                    irq_d   = 1'b1;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (cmd_fire_s && !abort_s) begin
            case (cmd_op_s)
                OP_NOP:   begin end
                OP_ABORT: begin end
                OP_LOAD_WORD: begin
                    if (busy_s || (cmd_idx_s > LAST_IDX)) err_d = 1'b1;
                    else                                 hdr_we_s = 1'b1;
                end
                OP_SET_NONCE: begin
                    if (busy_s) err_d = 1'b1;
                    else        nonce_d = cmd_data_s;
                end
                OP_START: begin
                    if (busy_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        widx_d  = 8'd0;
                        done_d  = 1'b0;
                        found_d = 1'b0;
                    end
                end
                OP_CLEAR_ERR: begin
                    err_d  = 1'b0;
`ifdef LA_MINER_IRQ_EN
                    pend_d = 1'b0;
`endif
                end
                default: err_d = 1'b1;
            endcase
        end else begin
            err_d = err_d;
        end

`ifdef LA_MINER_IRQ_EN
        if (irq_d) pend_d = 1'b1;
        else       pend_d = pend_d;
`endif
    end

    // State and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            widx_q  <= 8'd0;
            nonce_q <= {WORD_W{1'b0}};
            res_q   <= {WORD_W{1'b0}};
            found_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef LA_MINER_IRQ_EN
            irq_q   <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            nonce_q <= nonce_d;
            res_q   <= res_d;
            found_q <= found_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            abort_q <= abort_d;
`ifdef LA_MINER_IRQ_EN
            irq_q   <= irq_d;
            pend_q  <= pend_d;
`endif
        end
    end

    // Header register file.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < HDR_WORDS; i++) hdr_q[i] <= {WORD_W{1'b0}};
        end else if (hdr_we_s) begin
            hdr_q[cmd_idx_s[IDX_W-1:0]] <= cmd_data_s;
        end
    end

    // LA readback word assembled from registered state only.
    always_comb begin
        la_out_s               = 128'd0;
        la_out_s[WORD_W-1:0]   = res_q;
        la_out_s[LA_BUSY_BIT]  = busy_s;
        la_out_s[LA_DONE_BIT]  = done_q;
        la_out_s[LA_FOUND_BIT] = found_q;
        la_out_s[LA_ERR_BIT]   = err_q;
`ifdef LA_MINER_IRQ_EN
        la_out_s[LA_IRQ_BIT]   = pend_q;
`endif
    end

    assign la_data_out      = la_out_s;
    assign status_o         = status_word(STATUS_TAG, state_q, found_q);
    assign core.hdr_valid   = hdr_valid_s;
    assign core.hdr_idx     = hdr_valid_s ? widx_q : 8'd0;
    assign core.hdr_data    = hdr_valid_s ? hdr_q[widx_q[IDX_W-1:0]] : {WORD_W{1'b0}};
    assign core.core_start  = start_q;
    assign core.core_abort  = abort_q;
    assign core.nonce_start = nonce_q;
`ifdef LA_MINER_IRQ_EN
    assign irq              = irq_q;
`endif

endmodule

// File: tb/tb_la_miner_ctrl.sv
// Self-checking bench for la_miner_ctrl: directed job scenarios followed by
// randomized commands, all compared every cycle against a behavioural model.
module tb_la_miner_ctrl;
    localparam int N = 19;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] la_in;
    logic [127:0] la_oenb;
    logic [127:0] la_out;
    logic [15:0]  status;
`ifdef LA_MINER_IRQ_EN
    logic         irq;
`endif

    la_miner_ctrl_if #(.WORD_W(32)) bus ();

    la_miner_ctrl #(.HDR_WORDS(N), .WORD_W(32), .STATUS_TAG(8'hAB)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .la_data_in  (la_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_out),
        .status_o    (status),
`ifdef LA_MINER_IRQ_EN
        .irq         (irq),
`endif
        .core        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model state
    int          m_st;
    int          m_widx;
    logic [31:0] m_hdr [N];
    logic [31:0] snap [N];
    logic [31:0] m_nonce, m_res;
    logic        m_found, m_done, m_err, m_pend, m_start, m_abort, m_irq;
    logic        m_s1_v;
    logic [2:0]  m_s1_op;
    logic [7:0]  m_s1_idx;
    logic [31:0] m_s1_data;
    logic        m_last_strb;

    int   hs_next, hs_total, starts_seen, aborts_seen, irqs_seen;
    logic strb_tog = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] exp_la();
        logic [127:0] r;
        r        = 128'd0;
        r[31:0]  = m_res;
        r[32]    = (m_st == 1) || (m_st == 2);
        r[33]    = m_done;
        r[34]    = m_found;
        r[35]    = m_err;
`ifdef LA_MINER_IRQ_EN
        r[36]    = m_pend;
`endif
        return r;
    endfunction

    task automatic model_edge();
        logic [2:0]  op;
        logic [7:0]  idx;
        logic [31:0] data;
        logic        strb, ab, busy;
        data = (la_oenb[31:0] == 32'd0) ? la_in[31:0] : 32'd0;
        op   = (la_oenb[34:32] == 3'd0) ? la_in[34:32] : 3'd0;
        idx  = (la_oenb[47:40] == 8'd0) ? la_in[47:40] : 8'd0;
        strb = la_in[63] & ~la_oenb[63];
        m_start = 1'b0; m_abort = 1'b0; m_irq = 1'b0;
        if (rst) begin
            m_st = 0; m_widx = 0; m_nonce = 32'd0; m_res = 32'd0;
            m_found = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
            for (int i = 0; i < N; i++) m_hdr[i] = 32'd0;
            m_s1_v = 1'b0; m_last_strb = strb;
            return;
        end
        busy = (m_st == 1) || (m_st == 2);
        ab   = m_s1_v && (m_s1_op == 3'd4) && busy;
        if (ab) begin
            m_st = 0; m_abort = 1'b1;
        end else if (m_st == 1 && bus.hdr_ready) begin
            if (m_widx == N - 1) begin m_st = 2; m_start = 1'b1; end
            else m_widx++;
        end else if (m_st == 2 && bus.core_done) begin
            m_st = 3; m_found = bus.core_found; m_res = bus.core_nonce; m_done = 1'b1; m_irq = 1'b1;
        end
        if (m_s1_v && !ab) begin
            case (m_s1_op)
                3'd1: if (busy || m_s1_idx >= N) m_err = 1'b1; else m_hdr[m_s1_idx] = m_s1_data;
                3'd2: if (busy) m_err = 1'b1; else m_nonce = m_s1_data;
                3'd3: if (busy) m_err = 1'b1;
                      else begin m_st = 1; m_widx = 0; m_done = 1'b0; m_found = 1'b0; snap = m_hdr; hs_next = 0; end
                3'd5: begin m_err = 1'b0; m_pend = 1'b0; end
                3'd6, 3'd7: m_err = 1'b1;
                default: ;
            endcase
        end
`ifdef LA_MINER_IRQ_EN
        if (m_irq) m_pend = 1'b1;
`endif
        m_s1_v = (strb != m_last_strb); m_s1_op = op; m_s1_idx = idx; m_s1_data = data;
        m_last_strb = strb;
    endtask

    // One clock: observe the handshake, advance DUT and model, compare outputs.
    task automatic cycle();
        if (bus.hdr_valid === 1'b1 && bus.hdr_ready) begin
            chk("hs_in_range", hs_next < N, 1'b1);
            if (hs_next < N) begin
                chk("hs_idx", bus.hdr_idx, hs_next);
                chk("hs_data", bus.hdr_data, snap[hs_next]);
            end
            hs_next++; hs_total++;
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("la_data_out", la_out, exp_la());
        chk("status_o", status, {8'hAB, 2'b01, 2'(m_st), 3'b000, m_found});
        chk("hdr_valid", bus.hdr_valid, m_st == 1);
        if (m_st == 1) begin
            chk("hdr_idx", bus.hdr_idx, m_widx);
            chk("hdr_data", bus.hdr_data, m_hdr[m_widx]);
        end
        chk("core_start", bus.core_start, m_start);
        chk("core_abort", bus.core_abort, m_abort);
        chk("nonce_start", bus.nonce_start, m_nonce);
`ifdef LA_MINER_IRQ_EN
        chk("irq", irq, m_irq);
        if (irq) irqs_seen++;
`endif
        if (bus.core_start) starts_seen++;
        if (bus.core_abort) aborts_seen++;
    endtask

    task automatic put_cmd(input logic [2:0] op, input logic [7:0] idx, input logic [31:0] data);
        la_in[31:0]  = data;
        la_in[34:32] = op;
        la_in[47:40] = idx;
        strb_tog     = ~strb_tog;
        la_in[63]    = strb_tog;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] idx, input logic [31:0] data);
        put_cmd(op, idx, data);
        cycle();
        cycle();
    endtask

    initial begin
        rst = 1'b1; la_in = 128'd0; la_oenb = 128'd0;
        bus.hdr_ready = 1'b0; bus.core_done = 1'b0; bus.core_found = 1'b0; bus.core_nonce = 32'd0;
        hs_next = 0; hs_total = 0; starts_seen = 0; aborts_seen = 0; irqs_seen = 0;
        for (int i = 0; i < N; i++) snap[i] = 32'd0;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // 1: idle after reset
        chk("t1_status", status, 16'hAB40);
        chk("t1_la_out", la_out, 128'd0);
        chk("t1_hdr_valid", bus.hdr_valid, 1'b0);
        chk("t1_core_start", bus.core_start, 1'b0);

        // 2: load, set nonce, start, stream with hdr_ready toggling
        for (int i = 0; i < N; i++) send(3'd1, 8'(i), 32'h1000 + 32'(i));
        send(3'd2, 8'd0, 32'h0000_0100);
        hs_total = 0; starts_seen = 0;
        send(3'd3, 8'd0, 32'd0);
        chk("t2_status_load", status, 16'hAB50);
        for (int k = 0; k < 100 && m_st != 2; k++) begin
            bus.hdr_ready = ~bus.hdr_ready;
            cycle();
        end
        bus.hdr_ready = 1'b0;
        cycle();
        chk("t2_handshakes", hs_total, 19);
        chk("t2_start_pulses", starts_seen, 1);
        chk("t2_status", status, 16'hAB60);
        chk("t2_nonce_start", bus.nonce_start, 32'h0000_0100);

        // 3: result capture
        bus.core_done = 1'b1; bus.core_found = 1'b1; bus.core_nonce = 32'hDEAD_BEEF;
        cycle();
        bus.core_done = 1'b0; bus.core_found = 1'b0;
        chk("t3_status", status, 16'hAB71);
        chk("t3_nonce", la_out[31:0], 32'hDEAD_BEEF);
        chk("t3_done", la_out[33], 1'b1);
        chk("t3_found", la_out[34], 1'b1);

        // 4: ABORT coinciding with core_done in RUN
        send(3'd3, 8'd0, 32'd0);
        bus.hdr_ready = 1'b1;
        for (int k = 0; k < 100 && m_st != 2; k++) cycle();
        bus.hdr_ready = 1'b0;
        aborts_seen = 0;
        put_cmd(3'd4, 8'd0, 32'd0);
        cycle();
        bus.core_done = 1'b1; bus.core_found = 1'b1; bus.core_nonce = 32'h1234_5678;
        cycle();
        bus.core_done = 1'b0; bus.core_found = 1'b0;
        chk("t4_abort_pulse", aborts_seen, 1);
        chk("t4_status", status, 16'hAB40);
        chk("t4_found", la_out[34], 1'b0);
        chk("t4_nonce", la_out[31:0], 32'hDEAD_BEEF);

        // 5: illegal commands during LOAD
        send(3'd3, 8'd0, 32'd0);
        send(3'd1, 8'd19, 32'h0000_AAAA);
        chk("t5_err_set", la_out[35], 1'b1);
        send(3'd3, 8'd0, 32'd0);
        chk("t5_status_load", status, 16'hAB50);
        send(3'd5, 8'd0, 32'd0);
        chk("t5_err_clr", la_out[35], 1'b0);

        // 6: reset mid-LOAD
        aborts_seen = 0;
        rst = 1'b1;
        cycle();
        chk("t6_status", status, 16'hAB40);
        chk("t6_la_out", la_out, 128'd0);
        chk("t6_hdr_valid", bus.hdr_valid, 1'b0);
        chk("t6_no_abort", aborts_seen, 0);
        rst = 1'b0;
        cycle();
        send(3'd1, 8'd19, 32'h0000_5555);
        chk("t6_idx_bound_err", la_out[35], 1'b1);
        send(3'd5, 8'd0, 32'd0);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            int r;
            bus.hdr_ready  = 1'($urandom_range(0, 1));
            bus.core_done  = ($urandom_range(0, 9) == 0);
            bus.core_found = 1'($urandom_range(0, 1));
            bus.core_nonce = $urandom;
            rst            = ($urandom_range(0, 599) == 0);
            la_oenb        = 128'd0;
            if ($urandom_range(0, 19) == 0) la_oenb[$urandom_range(0, 63)] = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 15);
                put_cmd((r < 5) ? 3'd1 : (r < 7) ? 3'd2 : (r < 10) ? 3'd3 : (r < 12) ? 3'd4 :
                        (r == 12) ? 3'd5 : (r == 13) ? 3'd0 : (r == 14) ? 3'd6 : 3'd7,
                        8'($urandom_range(0, 21)), $urandom);
            end
            cycle();
        end
        rst = 1'b0; la_oenb = 128'd0;
        bus.core_done = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
